// File: rtl/rv_wb_ctrl_pkg.sv
// rv_wb_ctrl_pkg: register-file constants and helpers shared by the writeback block
package rv_wb_ctrl_pkg;
   localparam int REG_W = 5;
   localparam int NREG = 32;
   // x0 never maps to a scoreboard bit
   function automatic logic [NREG-1:0] reg_bit(input logic [REG_W-1:0] r);
      return (r == '0) ? '0 : NREG'(1) << r;
   endfunction
endpackage

// File: rtl/rv_wb_fifo.sv
// rv_wb_fifo: in-order load-result buffer with wrapping pointers and occupancy count
module rv_wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   assign head  = mem[rd_ptr];
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/rv_wb_ctrl.sv
// rv_wb_ctrl: writeback arbiter between ALU and buffered load results,
// with a load scoreboard and a registered register-file write port.
`ifndef XLEN
`define XLEN 32
`endif
module rv_wb_ctrl
   import rv_wb_ctrl_pkg::*;
#(
   parameter int XLEN       = `XLEN,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             i_wb_clk,
   input  logic             i_wb_rstn,
   input  logic             i_wb_alu_vld,
   input  logic [4:0]       i_wb_alu_rd,
   input  logic [XLEN-1:0]  i_wb_alu_data,
   output logic             o_wb_alu_hold,
   input  logic             i_wb_lsu_vld,
   input  logic [4:0]       i_wb_lsu_rd,
   input  logic [XLEN-1:0]  i_wb_lsu_data,
   output logic             o_wb_lsu_rdy,
   input  logic             i_wb_iss_vld,
   input  logic [4:0]       i_wb_iss_rd,
   input  logic [4:0]       i_wb_ra1,
   input  logic [4:0]       i_wb_ra2,
   output logic             o_wb_stall,
   output logic [31:0]      o_wb_busy,
   output logic             o_wb_rf_we,
   output logic [4:0]       o_wb_rf_wa,
   output logic [XLEN-1:0]  o_wb_rf_wd
);
   logic                    alu_wr, sel_alu, pop, push, fifo_full, fifo_empty;
   logic [REG_W+XLEN-1:0]   head;
   logic [REG_W-1:0]        head_rd;
   logic [XLEN-1:0]         head_data;
   logic [NREG-1:0]         busy, busy_nxt;
   assign alu_wr        = i_wb_alu_vld && (i_wb_alu_rd != '0);
   // a full buffer always drains, so the ALU waits while loads back up
   assign sel_alu       = alu_wr && !fifo_full;
   assign pop           = !fifo_empty && !sel_alu;
   assign o_wb_alu_hold = alu_wr && fifo_full;
   assign o_wb_lsu_rdy  = !fifo_full || pop;
   assign push          = i_wb_lsu_vld && o_wb_lsu_rdy && (i_wb_lsu_rd != '0);
   assign head_rd       = head[REG_W+XLEN-1:XLEN];
   assign head_data     = head[XLEN-1:0];
   rv_wb_fifo #(.W(REG_W+XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (i_wb_clk),
      .rst_n (i_wb_rstn),
      .push  (push),
      .pop   (pop),
      .din   ({i_wb_lsu_rd, i_wb_lsu_data}),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
   // set is applied after clear so a same-cycle reissue keeps the bit
   assign busy_nxt = (busy & ~(pop ? reg_bit(head_rd) : '0))
                   | (i_wb_iss_vld ? reg_bit(i_wb_iss_rd) : '0);
   always_ff @(posedge i_wb_clk or negedge i_wb_rstn)
      if (!i_wb_rstn) begin
         o_wb_rf_we <= 1'b0;
         o_wb_rf_wa <= '0;
         o_wb_rf_wd <= '0;
         busy       <= '0;
      end else begin
         o_wb_rf_we <= sel_alu || pop;
         if (sel_alu) begin
            o_wb_rf_wa <= i_wb_alu_rd;
            o_wb_rf_wd <= i_wb_alu_data;
         end else if (pop) begin
            o_wb_rf_wa <= head_rd;
            o_wb_rf_wd <= head_data;
         end
         busy <= busy_nxt;
      end
   assign o_wb_busy  = busy;
   assign o_wb_stall = busy[i_wb_ra1] | busy[i_wb_ra2];
endmodule
